regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised integer register file: NREG x XLEN, NRD registered read ports, one write port.
//  Each read port has a per-port external forward override.
//  Includes a pending-write scoreboard that flags read operands whose producer has not written back.
//  Sits between decode (issue/read) and writeback in the RV32I pipeline.
// PARAMETERS
//  XLEN  32  data width of each register and each read/write port
//  NREG  32  number of architectural registers; x0 is hardwired to zero
//  NRD   2   number of read ports (1..4)
//  AW    $clog2(NREG)  register address width; derived, do not override
// PORTS
//  CLK          in   1        clock; all state updates on posedge
//  RSTN         in   1        synchronous active-low reset, sampled on posedge CLK
//  rd_wen       in   1        writeback enable
//  rd           in   AW       writeback register address
//  rd_data      in   XLEN     writeback data
//  rs_addr      in   NRD*AW   read address, port p at [p*AW +: AW]
//  rs_ren       in   NRD      read-capture enable per port
//  rs_fwd       in   NRD      external forward select per port
//  rs_fwd_data  in   NRD*XLEN external forward data per port
//  rs_data      out  NRD*XLEN registered read data per port
//  rs_busy      out  NRD      comb: operand at rs_addr[p] has a pending producer
//  iss_valid    in   1        instruction issued with destination iss_rd
//  iss_rd       in   AW       destination of the issued instruction
// BEHAVIOUR
//  Reset (RSTN=0 at posedge)
//   - Registers 1..NREG-1 <= 0; rs_data <= 0 on all ports; scoreboard <= all 0.
//   - Reset overrides all same-cycle writes, issues and reads.
//  Write
//   - rd_wen && rd!=0: reg[rd] <= rd_data at posedge.
//   - rd==0 writes are dropped; reg[0] always reads 0.
//   - rd >= NREG (non-power-of-two NREG): write is ignored.
//  Read, per port p, 1-cycle latency; rs_data[p] holds its value when rs_ren[p]=0
//   - rs_ren[p]=1: rs_data[p] <= sel at posedge.
//   - sel priority: rs_fwd[p] ? rs_fwd_data[p] : bypass (if enabled) : reg[rs_addr[p]].
//   - rs_addr[p]==0 with rs_fwd[p]=0 always captures 0.
//   - rs_addr[p] >= NREG captures 0.
//   - Ports are independent; several ports may read the same address in one cycle.
//  Scoreboard (sb[NREG], sb[0] tied to 0)
//   - Set: iss_valid && iss_rd!=0 -> sb[iss_rd] <= 1.
//   - Clear: rd_wen && rd!=0 -> sb[rd] <= 0.
//   - Same register set and cleared in one cycle: set wins (newer producer).
//   - Different registers set and cleared in one cycle: both take effect.
//   - rs_busy[p] = sb[rs_addr[p]] & (rs_addr[p]!=0), from the current state only.
//   - rs_busy is not cleared by a same-cycle writeback; consumers apply rs_fwd for that case.
//  The block raises no errors; hazard stalling is the issue stage's responsibility.
// CONFIGURATION
//  RF_WR_BYPASS_EN
//   - Defined: same-cycle rd_wen && rd==rs_addr[p] && rd!=0 selects rd_data (write-through);
//     external rs_fwd still has priority over it.
//   - Undefined: the read captures the pre-write array value;
//     the caller forwards writeback data through rs_fwd.
// STRUCTURE
//  Package rf_pkg
//   - Default constants RF_XLEN=32, RF_NREG=32, RF_NRD=2.
//   - Function rf_aw(n) returning the clog2 address width.
//   - typedef rf_addr_t for the default address width.
//  Sub-module rf_scoreboard
//   - Parameters NREG, AW.
//   - Holds the sb vector, set/clear logic and per-port busy lookup; instantiated once.
//  Top-level body: register array, per-port read mux and capture flops.
// TESTING
//  1. Reset: drive RSTN=0 one cycle, then read x1..x31 on every port
//     -> rs_data=0 and rs_busy=0 on every read.
//  2. x0 handling: write x0=32'hDEAD_BEEF, then read x0 on port 0 -> rs_data[0]=0.
//     Issue iss_rd=0 -> rs_busy stays 0.
//  3. Write/read: write x5=32'h1234_5678, next cycle rs_addr={5,5} with rs_ren=2'b11
//     -> both ports =32'h1234_5678 one cycle later.
//     Then rs_ren=0 -> values held.
//  4. Forward/bypass: write x7=A while port 1 reads x7 in the same cycle.
//     With RF_WR_BYPASS_EN -> A; without -> old value.
//     Adding rs_fwd[1]=1, data=B -> B in both builds.
//  5. Scoreboard: issue x9 -> rs_busy=1 for a port reading x9.
//     Writeback x9 -> busy=0 next cycle.
//     Issue x9 and writeback x9 in the same cycle -> busy stays 1.
//  6. Mid-operation reset: sb has x3 and x4 set and rs_data is nonzero;
//     assert RSTN=0 together with rd_wen and iss_valid -> all state 0 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, address-width helper and address type for the register file
package rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [rf_aw(RF_NREG)-1:0] rf_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bit per register, set on issue, cleared on writeback, x0 never busy
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = rf_aw(NREG),
  parameter int NRD  = RF_NRD
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              rd_wen,
  input  logic [AW-1:0]     rd,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD-1:0]    rs_busy
);
  logic [NREG-1:0] sb_q, sb_d;
  // clear on writeback first so a same-register issue (newer producer) wins
  always_comb begin
    sb_d = sb_q;
    if (rd_wen && rd != '0 && 32'(rd) < NREG) sb_d[rd] = 1'b0;
    if (iss_valid && iss_rd != '0 && 32'(iss_rd) < NREG) sb_d[iss_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end
  // scoreboard state register
  always_ff @(posedge CLK)
    if (!RSTN) sb_q <= '0;
    else sb_q <= sb_d;
  for (genvar p = 0; p < NRD; p++) begin : g_busy
    logic [AW-1:0] a;
    assign a = rs_addr[p*AW +: AW];
    assign rs_busy[p] = a != '0 && 32'(a) < NREG && sb_q[a];
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: NREG x XLEN register file, NRD registered read ports with forward override, one write port,
// pending-write scoreboard; define RF_WR_BYPASS_EN for same-cycle write-through on reads
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = RF_NRD,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                rd_wen,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     rd_data,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_ren,
  input  logic [NRD-1:0]      rs_fwd,
  input  logic [NRD*XLEN-1:0] rs_fwd_data,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);
  logic [XLEN-1:0] mem_q [NREG];
  logic [NRD*XLEN-1:0] rs_data_q, rs_data_d;
  logic wr_ok;
  assign wr_ok = rd_wen && rd != '0 && 32'(rd) < NREG;
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] arr, sel;
    assign a = rs_addr[p*AW +: AW];
    assign arr = (a != '0 && 32'(a) < NREG) ? mem_q[a] : '0;
`ifdef RF_WR_BYPASS_EN
    assign sel = rs_fwd[p] ? rs_fwd_data[p*XLEN +: XLEN] : (wr_ok && rd == a) ? rd_data : arr;
`else
    assign sel = rs_fwd[p] ? rs_fwd_data[p*XLEN +: XLEN] : arr;
`endif
    assign rs_data_d[p*XLEN +: XLEN] = rs_ren[p] ? sel : rs_data_q[p*XLEN +: XLEN];
  end
  // register array; x0 is cleared by reset and never written
  always_ff @(posedge CLK)
    if (!RSTN) for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    else if (wr_ok) mem_q[rd] <= rd_data;
  // read capture flops, holding when a port is not enabled
  always_ff @(posedge CLK)
    if (!RSTN) rs_data_q <= '0;
    else rs_data_q <= rs_data_d;
  assign rs_data = rs_data_q;
  rf_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD)) u_sb (
    .CLK(CLK), .RSTN(RSTN), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rd_wen(rd_wen), .rd(rd), .rs_addr(rs_addr), .rs_busy(rs_busy)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed vector table plus randomized traffic against an array-based reference model
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  logic CLK = 1'b0;
  logic RSTN, rd_wen, iss_valid;
  logic [AW-1:0] rd, iss_rd;
  logic [XLEN-1:0] rd_data;
  logic [AW-1:0] a [NRD];
  logic [XLEN-1:0] fd [NRD];
  logic [NRD-1:0] rs_ren, rs_fwd, rs_busy;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_fwd_data, rs_data;
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] m_reg [NREG];
  bit m_sb [NREG];
  logic [XLEN-1:0] m_data [NRD];
  for (genvar g = 0; g < NRD; g++) begin : g_pack
    assign rs_addr[g*AW +: AW] = a[g];
    assign rs_fwd_data[g*XLEN +: XLEN] = fd[g];
  end
  always #5 CLK = ~CLK;
  regfile_mp_sb dut (
    .CLK(CLK), .RSTN(RSTN), .rd_wen(rd_wen), .rd(rd), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_ren(rs_ren), .rs_fwd(rs_fwd), .rs_fwd_data(rs_fwd_data),
    .rs_data(rs_data), .rs_busy(rs_busy), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );
  typedef struct {
    int rstn, wen, rd;
    logic [31:0] wd;
    int a0, a1, ren, fwd;
    logic [31:0] f1;
    int iv, ird;
    logic [31:0] e0, e1;
    int eb;
  } vec_t;
  vec_t tv [14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // reference model: the architectural effect of one clock edge
  task automatic model_edge();
    logic [XLEN-1:0] v;
    if (!RSTN) begin
      for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_sb[i] = 0; end
      for (int p = 0; p < NRD; p++) m_data[p] = '0;
      return;
    end
    for (int p = 0; p < NRD; p++)
      if (rs_ren[p]) begin
        v = (a[p] == 0) ? '0 : m_reg[a[p]];
`ifdef RF_WR_BYPASS_EN
        if (rd_wen && rd != 0 && rd == a[p]) v = rd_data;
`endif
        if (rs_fwd[p]) v = fd[p];
        m_data[p] = v;
      end
    if (rd_wen && rd != 0) begin m_reg[rd] = rd_data; m_sb[rd] = 0; end
    if (iss_valid && iss_rd != 0) m_sb[iss_rd] = 1;
  endtask
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask
  task automatic check_model(input string name);
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s data p%0d", name, p), rs_data[p*XLEN +: XLEN], m_data[p]);
      check($sformatf("%s busy p%0d", name, p), 32'(rs_busy[p]), 32'(a[p] != 0 && m_sb[a[p]]));
    end
  endtask
  task automatic idle();
    RSTN = 1'b1; rd_wen = 1'b0; rd = '0; rd_data = '0; iss_valid = 1'b0; iss_rd = '0;
    rs_ren = '0; rs_fwd = '0;
    for (int p = 0; p < NRD; p++) begin a[p] = '0; fd[p] = '0; end
  endtask
  initial begin
    logic [31:0] byp;
`ifdef RF_WR_BYPASS_EN
    byp = 32'hAAAA0000;
`else
    byp = 32'h11111111;
`endif
    tv[0]  = '{0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0};
    tv[1]  = '{1, 1, 0, 32'hDEADBEEF, 0, 0, 3, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0};
    tv[2]  = '{1, 1, 5, 32'h12345678, 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0};
    tv[3]  = '{1, 0, 0, 32'h0, 5, 5, 3, 0, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 0};
    tv[4]  = '{1, 1, 7, 32'h11111111, 0, 0, 0, 0, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 0};
    tv[5]  = '{1, 1, 7, 32'hAAAA0000, 0, 7, 2, 0, 32'h0, 0, 0, 32'h12345678, byp, 0};
    tv[6]  = '{1, 1, 7, 32'hCCCC0000, 0, 7, 2, 2, 32'hBBBB0000, 0, 0, 32'h12345678, 32'hBBBB0000, 0};
    tv[7]  = '{1, 0, 0, 32'h0, 9, 9, 0, 0, 32'h0, 1, 9, 32'h12345678, 32'hBBBB0000, 3};
    tv[8]  = '{1, 1, 9, 32'h99, 9, 9, 0, 0, 32'h0, 0, 0, 32'h12345678, 32'hBBBB0000, 0};
    tv[9]  = '{1, 1, 9, 32'h98, 9, 9, 0, 0, 32'h0, 1, 9, 32'h12345678, 32'hBBBB0000, 3};
    tv[10] = '{1, 0, 0, 32'h0, 9, 9, 1, 0, 32'h0, 1, 3, 32'h98, 32'hBBBB0000, 3};
    tv[11] = '{1, 0, 0, 32'h0, 3, 4, 0, 0, 32'h0, 1, 4, 32'h98, 32'hBBBB0000, 3};
    tv[12] = '{0, 1, 3, 32'h5, 3, 4, 3, 0, 32'h0, 1, 6, 32'h0, 32'h0, 0};
    tv[13] = '{1, 0, 0, 32'h0, 5, 9, 3, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0};
    idle();
    for (int i = 0; i < 14; i++) begin
      RSTN = 1'(tv[i].rstn); rd_wen = 1'(tv[i].wen); rd = AW'(tv[i].rd); rd_data = tv[i].wd;
      a[0] = AW'(tv[i].a0); a[1] = AW'(tv[i].a1); rs_ren = 2'(tv[i].ren); rs_fwd = 2'(tv[i].fwd);
      fd[0] = 32'h0; fd[1] = tv[i].f1; iss_valid = 1'(tv[i].iv); iss_rd = AW'(tv[i].ird);
      step();
      check($sformatf("vec%0d data p0", i), rs_data[31:0], tv[i].e0);
      check($sformatf("vec%0d data p1", i), rs_data[63:32], tv[i].e1);
      check($sformatf("vec%0d busy", i), 32'(rs_busy), 32'(tv[i].eb));
    end
    idle();
    for (int r = 1; r < NREG; r++) begin
      a[0] = AW'(r); a[1] = AW'(r); rs_ren = 2'b11;
      step();
      check($sformatf("post-reset x%0d p0", r), rs_data[31:0], 32'h0);
      check($sformatf("post-reset x%0d p1", r), rs_data[63:32], 32'h0);
      check($sformatf("post-reset busy x%0d", r), 32'(rs_busy), 32'h0);
    end
    for (int n = 0; n < 600; n++) begin
      RSTN = ($urandom_range(0, 49) != 0);
      rd_wen = 1'($urandom_range(0, 1));
      rd = AW'($urandom_range(0, 7));
      rd_data = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) begin
        a[p] = AW'($urandom_range(0, 7));
        fd[p] = $urandom;
      end
      rs_ren = 2'($urandom);
      rs_fwd = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step();
      check_model($sformatf("rand%0d", n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
